debug_trace_capture: RTL and testbench

//  Consumer end of the cpu 16-bit debug port: samples debug every clk, logs each change
//  as a timestamped entry {ts, value} in an internal FIFO, and hands entries to a

---
 rtl/debug_trace_capture_pkg.sv | 15 +
 rtl/debug_trace_capture_if.sv | 15 +
 rtl/debug_trace_capture_fifo.sv | 80 ++++++++
 rtl/debug_trace_capture.sv | 114 +++++++++++
 tb/tb_debug_trace_capture.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_trace_capture_pkg.sv
// Shared types and default sizes for the debug trace capture block.
package debug_trace_capture_pkg;

  localparam int DBG_W_DEF  = 16;
  localparam int TS_W_DEF   = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int DROP_W_DEF = 8;

  // Layout of one logged entry at default widths; timestamp occupies the MSBs.
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [DBG_W_DEF-1:0] dbg;
  } trace_entry_t;

endpackage

// File: rtl/debug_trace_capture_if.sv
// Valid/ready stream carrying timestamped trace entries to the reader.
interface debug_trace_capture_if
  import debug_trace_capture_pkg::*;
#(
  parameter int DATA_W = TS_W_DEF + DBG_W_DEF
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/debug_trace_capture_fifo.sv
// First-word-fall-through FIFO: the head entry is presented whenever non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module debug_trace_capture_fifo
  import debug_trace_capture_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF + DBG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // Head is forced to zero when empty so the output matches its reset value.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Resolve accepted push/pop and next occupancy; clear overrides both.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    level_nxt = level;
    if (!clear) begin
      rd_en = pop && !empty;
      wr_en = push && (!full || rd_en);
      if (wr_en && !rd_en) begin
        level_nxt = level + 1'b1;
      end else if (rd_en && !wr_en) begin
        level_nxt = level - 1'b1;
      end
    end else begin
      level_nxt = '0;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; stale slots are never visible because the head is gated by empty.
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/debug_trace_capture.sv
// Samples the cpu debug word every cycle and logs each change, with a cycle
// timestamp, into a FIFO drained by a downstream reader over valid/ready.
// Entries that find the FIFO full are dropped and counted.
module debug_trace_capture
  import debug_trace_capture_pkg::*;
#(
  parameter int DBG_W  = DBG_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DBG_W-1:0]        dbg_in,
  debug_trace_capture_if.master   trace_out,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt
);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [DBG_W-1:0] dbg;
  } entry_t;

  logic [DBG_W-1:0] dbg_q;
  logic             en_q;
  logic [TS_W-1:0]  ts;
  logic [DBG_W-1:0] last_logged;
  logic             armed;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  entry_t           entry;

  // A sample is logged on the first enabled cycle after arming, or on any change.
  assign push_req = en_q && (armed || (dbg_q != last_logged));
  assign pop      = trace_out.out_valid && trace_out.out_ready;
  // A pop in the same cycle frees the slot, so only an unrelieved full FIFO drops.
  assign drop     = push_req && fifo_full && !pop && !clear;
  assign entry    = '{ts: ts, dbg: dbg_q};

  // Input sampling stage: registered debug word and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_q <= '0;
      en_q  <= 1'b0;
    end else begin
      dbg_q <= dbg_in;
      en_q  <= enable;
    end
  end

  // Free-running timestamp, advancing only while capture is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (clear) begin
      ts <= '0;
    end else if (en_q) begin
      ts <= ts + 1'b1;
    end
  end

  // Change-detect state: remember the last attempted value; re-arm while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b1;
      last_logged <= '0;
    end else if (clear || !en_q) begin
      armed <= 1'b1;
    end else if (push_req) begin
      armed       <= 1'b0;
      last_logged <= dbg_q;
    end
  end

  // Dropped-entry accounting: sticky flag plus saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  debug_trace_capture_fifo #(
    .WIDTH (TS_W + DBG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_req),
    .wdata (entry),
    .pop   (pop),
    .rdata (trace_out.out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign trace_out.out_valid = !fifo_empty;

endmodule

// File: tb/tb_debug_trace_capture.sv
// Scoreboard bench for debug_trace_capture: stimulus pushes expected entries,
// a negedge monitor compares each accepted head entry against the queue.
module tb_debug_trace_capture;

  localparam int DBG_W  = 16;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 8;
  localparam int DW     = TS_W + DBG_W;

  logic                   clk;
  logic                   rst_n;
  logic                   enable;
  logic                   clear;
  logic [DBG_W-1:0]       dbg_in;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic [DROP_W-1:0]      drop_cnt;

  debug_trace_capture_if #(.DATA_W(DW)) trace_if ();

  debug_trace_capture #(
    .DBG_W  (DBG_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clear     (clear),
    .dbg_in    (dbg_in),
    .trace_out (trace_if),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Flush DUT and scoreboard with capture disabled; ts restarts at 0.
  task automatic start_clean;
    enable             = 1'b0;
    trace_if.out_ready = 1'b0;
    clear              = 1'b1;
    tick;
    clear = 1'b0;
    sb.delete();
    tick;
  endtask

  // Let the reader drain everything; bounded so a stuck DUT still ends.
  task automatic drain(input string name);
    int n;
    n = 0;
    trace_if.out_ready = 1'b1;
    while (level != 0 && n < 200) begin
      tick;
      n++;
    end
    trace_if.out_ready = 1'b0;
    check({name, "_level_zero"}, 64'(level), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: each entry the reader accepts must be the oldest expected one.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (rst_n && !clear && trace_if.out_valid && trace_if.out_ready) begin
      if (sb.size() == 0) begin
        check("mon_unexpected_entry", 64'(trace_if.out_data), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("mon_entry", 64'(trace_if.out_data), 64'(e));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n              = 1'b0;
    enable             = 1'b0;
    clear              = 1'b0;
    dbg_in             = '0;
    trace_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(trace_if.out_valid), 64'd0);
    check("rst_out_data",  64'(trace_if.out_data),  64'd0);
    check("rst_level",     64'(level),              64'd0);
    check("rst_overflow",  64'(overflow),           64'd0);
    check("rst_drop_cnt",  64'(drop_cnt),           64'd0);
    rst_n = 1'b1;
    tick;

    // T2: change logging and two-edge latency.
    enable = 1'b1;
    dbg_in = 16'h0001;
    sb.push_back({4'd0, 16'h0001});
    tick;
    check("t2_valid_after_1_edge", 64'(trace_if.out_valid), 64'd0);
    tick;
    check("t2_valid_after_2_edges", 64'(trace_if.out_valid), 64'd1);
    check("t2_head_first", 64'(trace_if.out_data), 64'({4'd0, 16'h0001}));
    tick;
    dbg_in = 16'h00A5;
    sb.push_back({4'd3, 16'h00A5});
    tick;
    check("t2_level_1_edge_after_change", 64'(level), 64'd1);
    tick;
    check("t2_level_2_edges_after_change", 64'(level), 64'd2);
    repeat (4) tick;
    check("t2_repeats_no_entry", 64'(level), 64'd2);
    enable = 1'b0;
    drain("t2");

    // T3: backpressure, 20 distinct values into 16 slots.
    start_clean;
    enable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      dbg_in = 16'(16'h1000 + j);
      if (j < 16) sb.push_back({4'(j), 16'(16'h1000 + j)});
      tick;
    end
    tick;
    enable = 1'b0;
    check("t3_level_full", 64'(level), 64'd16);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd4);
    check("t3_overflow", 64'(overflow), 64'd1);
    drain("t3");
    check("t3_overflow_sticky", 64'(overflow), 64'd1);

    // T6: clear with level 7 and a push in the same cycle.
    for (int j = 0; j < 8; j++) begin
      dbg_in = 16'(16'h4000 + j);
      enable = 1'b1;
      tick;
    end
    check("t6_level_before_clear", 64'(level), 64'd7);
    check("t6_drop_before_clear", 64'(drop_cnt), 64'd4);
    clear = 1'b1;
    tick;
    clear  = 1'b0;
    enable = 1'b0;
    sb.delete();
    sb.push_back({4'd0, 16'h4007});
    check("t6_level_cleared", 64'(level), 64'd0);
    check("t6_valid_cleared", 64'(trace_if.out_valid), 64'd0);
    check("t6_data_cleared", 64'(trace_if.out_data), 64'd0);
    check("t6_drop_cleared", 64'(drop_cnt), 64'd0);
    check("t6_overflow_cleared", 64'(overflow), 64'd0);
    tick;
    tick;
    check("t6_rearmed_entry", 64'(level), 64'd1);
    drain("t6");

    // T4: full FIFO with a simultaneous pop accepts the new entry.
    start_clean;
    enable = 1'b1;
    for (int j = 0; j < 17; j++) begin
      dbg_in = 16'(16'h2000 + j);
      sb.push_back({4'(j), 16'(16'h2000 + j)});
      tick;
    end
    check("t4_level_full", 64'(level), 64'd16);
    trace_if.out_ready = 1'b1;
    enable             = 1'b0;
    tick;
    trace_if.out_ready = 1'b0;
    check("t4_level_still_full", 64'(level), 64'd16);
    check("t4_drop_unchanged", 64'(drop_cnt), 64'd0);
    check("t4_no_overflow", 64'(overflow), 64'd0);
    drain("t4");

    // T5: re-arm with unchanged input, then timestamp wrap 15 -> 0.
    start_clean;
    enable = 1'b1;
    sb.push_back({4'd0, 16'h2010});
    for (int j = 1; j <= 20; j++) begin
      tick;
      if (j == 15) begin
        dbg_in = 16'h3001;
        sb.push_back({4'd15, 16'h3001});
      end else if (j == 16) begin
        dbg_in = 16'h3002;
        sb.push_back({4'd0, 16'h3002});
      end else if (j == 18) begin
        dbg_in = 16'h3000;
        sb.push_back({4'd2, 16'h3000});
      end
    end
    tick;
    check("t5_level", 64'(level), 64'd4);
    enable = 1'b0;
    drain("t5");

    // T1: asynchronous reset mid-stream with five entries queued.
    for (int j = 0; j < 5; j++) begin
      dbg_in = 16'(16'h5000 + j);
      enable = 1'b1;
      tick;
    end
    tick;
    check("t1_level_before_reset", 64'(level), 64'd5);
    sb.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_valid_async", 64'(trace_if.out_valid), 64'd0);
    check("t1_data_async", 64'(trace_if.out_data), 64'd0);
    check("t1_level_async", 64'(level), 64'd0);
    check("t1_overflow_async", 64'(overflow), 64'd0);
    check("t1_drop_async", 64'(drop_cnt), 64'd0);
    enable = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    check("t1_level_after_release", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
